// File: rtl/sign_mag_addsub_pipe_if.sv
// rtl/sign_mag_addsub_pipe_if.sv - operand/result handshake bundle for the sign-magnitude add/sub pipe
interface sign_mag_addsub_pipe_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         ovf;
  logic         clr_ovf;
  logic         ovf_sticky;

  modport master (
    output in_valid, a, b, sub, out_ready, clr_ovf,
    input  in_ready, out_valid, sum, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready, clr_ovf,
    output in_ready, out_valid, sum, ovf, ovf_sticky
  );
endinterface

// File: rtl/sign_mag_addsub_pipe.sv
// rtl/sign_mag_addsub_pipe.sv - two-stage sign-magnitude add/subtract with overflow, saturation and sticky flag
module sign_mag_addsub_pipe #(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  sign_mag_addsub_pipe_if.slave io
);
  localparam int M = N - 1;

  logic         s1_valid;
  logic         s1_sgn;
  logic         s1_same;
  logic [M-1:0] s1_max;
  logic [M-1:0] s1_min;

  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         ovf_q;
  logic         sticky_q;

  logic s1_en;
  logic s2_en;

  assign s2_en       = !out_valid_q || io.out_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign io.in_ready = s1_en && !reset;

  // Stage 1: fold subtract into B's sign, then order magnitudes so stage 2 never borrows
  logic         sb;
  logic         same;
  logic [M-1:0] ma;
  logic [M-1:0] mb;
  logic [M-1:0] max_d;
  logic [M-1:0] min_d;
  logic         sgn_d;

  always_comb begin
    sb    = io.b[N-1] ^ io.sub;
    ma    = io.a[M-1:0];
    mb    = io.b[M-1:0];
    same  = (io.a[N-1] == sb);
    max_d = ma;
    min_d = mb;
    sgn_d = io.a[N-1];
    if (ma < mb) begin
      max_d = mb;
      min_d = ma;
      sgn_d = sb;
    end else if (ma == mb && !same) begin
      sgn_d = 1'b0;
    end
  end

  // Stage 2: magnitude arithmetic, overflow handling, and -0 normalisation
  logic [N-1:0] raw;
  logic [M-1:0] mag;
  logic         carry;
  logic         sgn_out;

  always_comb begin
    if (s1_same) begin
      raw = {1'b0, s1_max} + {1'b0, s1_min};
    end else begin
      raw = {1'b0, s1_max - s1_min};
    end
    carry = raw[N-1];
    mag   = raw[M-1:0];
    if (carry && SAT) begin
      mag = '1;
    end
    sgn_out = (mag == '0) ? 1'b0 : s1_sgn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= io.in_valid && io.in_ready;
        if (io.in_valid) begin
          s1_max  <= max_d;
          s1_min  <= min_d;
          s1_sgn  <= sgn_d;
          s1_same <= same;
        end
      end
      if (s2_en) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          sum_q <= {sgn_out, mag};
          ovf_q <= carry;
        end
      end
      // Setting takes priority so an overflow leaving in the clear cycle is not lost
      if (out_valid_q && io.out_ready && ovf_q) begin
        sticky_q <= 1'b1;
      end else if (io.clr_ovf) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.sum        = sum_q;
  assign io.ovf        = ovf_q;
  assign io.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// tb/tb_sign_mag_addsub_pipe.sv - self-checking bench for sign_mag_addsub_pipe (saturating and wrapping builds)
module tb_sign_mag_addsub_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sign_mag_addsub_pipe_if #(.N(8)) if_s ();
  sign_mag_addsub_pipe_if #(.N(8)) if_w ();

  assign if_w.in_valid  = if_s.in_valid;
  assign if_w.a         = if_s.a;
  assign if_w.b         = if_s.b;
  assign if_w.sub       = if_s.sub;
  assign if_w.out_ready = if_s.out_ready;
  assign if_w.clr_ovf   = if_s.clr_ovf;

  sign_mag_addsub_pipe #(.N(8), .SAT(1'b1)) dut_sat (.clk(clk), .reset(reset), .io(if_s));
  sign_mag_addsub_pipe #(.N(8), .SAT(1'b0)) dut_wrap (.clk(clk), .reset(reset), .io(if_w));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       ovf;
    logic [7:0] sum_w;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  vec_t sb_q[$];
  vec_t cur_exp;
  logic m_sticky = 1'b0;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    vec_t v;
    int va, vb, r, mag, smag, wmag;
    logic neg;
    va = int'(a[6:0]);
    vb = int'(b[6:0]);
    if (a[7]) va = -va;
    if (b[7]) vb = -vb;
    if (sub) vb = -vb;
    r    = va + vb;
    neg  = (r < 0);
    mag  = neg ? -r : r;
    smag = (mag > 127) ? 127 : mag;
    wmag = mag % 128;
    v.a     = a;
    v.b     = b;
    v.sub   = sub;
    v.ovf   = (mag > 127);
    v.sum   = ((neg && smag != 0) ? 8'h80 : 8'h00) | 8'(smag);
    v.sum_w = ((neg && wmag != 0) ? 8'h80 : 8'h00) | 8'(wmag);
    return v;
  endfunction

  task automatic send_exp(input vec_t e);
    int n;
    cur_exp      = e;
    if_s.a       = e.a;
    if_s.b       = e.b;
    if_s.sub     = e.sub;
    if_s.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (if_s.in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
    send_exp(model(a, b, sub));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge clk) begin
    vec_t e;
    if (reset) begin
      sb_q.delete();
      m_sticky = 1'b0;
    end else begin
      chk("ovf_sticky", 32'(if_s.ovf_sticky), 32'(m_sticky));
      if (if_s.in_valid && if_s.in_ready) begin
        sb_q.push_back(cur_exp);
        acc_cnt++;
      end
      if (if_s.out_valid && if_s.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual sum=%0h required none", if_s.sum);
        end else begin
          e = sb_q.pop_front();
          chk("sum_sat", 32'(if_s.sum), 32'(e.sum));
          chk("ovf_sat", 32'(if_s.ovf), 32'(e.ovf));
          chk("valid_wrap", 32'(if_w.out_valid), 32'd1);
          chk("sum_wrap", 32'(if_w.sum), 32'(e.sum_w));
          chk("ovf_wrap", 32'(if_w.ovf), 32'(e.ovf));
          if (e.ovf) m_sticky = 1'b1;
          else if (if_s.clr_ovf) m_sticky = 1'b0;
        end
      end else if (if_s.clr_ovf) begin
        m_sticky = 1'b0;
      end
    end
  end

  initial begin
    int n, seen, base;
    bit done;
    tbl[0]  = '{8'h05, 8'h83, 1'b0, 8'h02, 1'b0, 8'h02};
    tbl[1]  = '{8'h83, 8'h03, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{8'h70, 8'h20, 1'b0, 8'h7F, 1'b1, 8'h10};
    tbl[5]  = '{8'h80, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{8'hF0, 8'hA0, 1'b0, 8'hFF, 1'b1, 8'h90};
    tbl[7]  = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 8'h02};
    tbl[8]  = '{8'h03, 8'h05, 1'b1, 8'h82, 1'b0, 8'h82};
    tbl[9]  = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 8'h7E};
    tbl[10] = '{8'h40, 8'h40, 1'b0, 8'h7F, 1'b1, 8'h00};
    tbl[11] = '{8'hC0, 8'h40, 1'b1, 8'hFF, 1'b1, 8'h00};
    tbl[12] = '{8'h85, 8'h02, 1'b0, 8'h83, 1'b0, 8'h83};
    tbl[13] = '{8'h7F, 8'h01, 1'b1, 8'h7E, 1'b0, 8'h7E};
    tbl[14] = '{8'h00, 8'h7F, 1'b1, 8'hFF, 1'b0, 8'hFF};

    reset = 1'b1;
    if_s.in_valid = 1'b0;
    if_s.a = 8'h00;
    if_s.b = 8'h00;
    if_s.sub = 1'b0;
    if_s.out_ready = 1'b0;
    if_s.clr_ovf = 1'b0;
    cur_exp = model(8'h00, 8'h00, 1'b0);

    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(if_s.in_ready), 32'd0);
    chk("rst_out_valid", 32'(if_s.out_valid), 32'd0);
    chk("rst_sum", 32'(if_s.sum), 32'd0);
    chk("rst_ovf", 32'(if_s.ovf), 32'd0);
    chk("rst_sticky", 32'(if_s.ovf_sticky), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(if_s.in_ready), 32'd1);

    // Two-cycle latency from accept to out_valid
    if_s.out_ready = 1'b1;
    send_exp(tbl[0]);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(if_s.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(if_s.out_valid), 32'd1);
    chk("lat_cycle2_sum", 32'(if_s.sum), 32'h02);
    drain();

    for (int i = 0; i < 15; i++) send_exp(tbl[i]);
    drain();

    // Five back-to-back pairs against a 4-cycle output stall
    if_s.out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b1);
        send(8'hF0, 8'h20, 1'b0);
        send(8'h05, 8'h85, 1'b0);
        send(8'h7F, 8'h7F, 1'b0);
      end
    join_none
    repeat (4) @(posedge clk);
    #1;
    chk("stall_accepted", 32'(acc_cnt - base), 32'd2);
    chk("stall_in_ready", 32'(if_s.in_ready), 32'd0);
    if_s.out_ready = 1'b1;
    wait fork;
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if_s.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    if_s.out_ready = 1'b1;
    drain();

    // clr_ovf coincident with an overflowing transfer: set wins
    if_s.clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    if_s.clr_ovf = 1'b0;
    chk("sticky_pre_clear", 32'(if_s.ovf_sticky), 32'd0);
    if_s.out_ready = 1'b0;
    send(8'h70, 8'h20, 1'b0);
    n = 0;
    while (!if_s.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sticky_wait_valid", 32'(if_s.out_valid), 32'd1);
    if_s.clr_ovf = 1'b1;
    if_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sticky_set_wins", 32'(if_s.ovf_sticky), 32'd1);
    if_s.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("sticky_cleared", 32'(if_s.ovf_sticky), 32'd0);
    if_s.clr_ovf = 1'b0;

    // Reset with two results in flight
    if_s.out_ready = 1'b1;
    send(8'h7F, 8'h01, 1'b0);
    drain();
    chk("sticky_before_rst", 32'(if_s.ovf_sticky), 32'd1);
    if_s.out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    send(8'h56, 8'h78, 1'b0);
    chk("inflight_valid", 32'(if_s.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(if_s.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", 32'(if_s.out_valid), 32'd0);
    chk("rst_mid_sum", 32'(if_s.sum), 32'd0);
    chk("rst_mid_sticky", 32'(if_s.ovf_sticky), 32'd0);
    reset = 1'b0;
    if_s.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_s.out_valid) seen++;
    end
    chk("no_stale_output", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
